// File: rtl/key_sw_ctrl_pkg.sv
// rtl/key_sw_ctrl_pkg.sv - shared constants and status helper for key_sw_ctrl
//
// Purpose: default register addresses, CTRL offset, CTRL bit positions,
//          the per-device status record and its next-state function.
// Ports:   none (package).
package key_sw_ctrl_pkg;

  localparam logic [31:0] ADDRKEY_DEFAULT = 32'hFFFFF080;
  localparam logic [31:0] ADDRSW_DEFAULT  = 32'hFFFFF090;
  localparam int          CTRL_OFFSET     = 4;

  localparam int BIT_READY   = 0;
  localparam int BIT_OVERRUN = 2;
  localparam int BIT_IE      = 8;

  typedef struct packed {
    logic ie;
    logic overrun;
    logic ready;
  } dev_status_t;

  // Clear sources are applied first and set sources last, so a debounced
  // change always wins over a same-cycle clear of Ready or Overrun.
  // Overrun is judged against the Ready value held before this edge, and a
  // same-cycle data read counts as consuming the previous value.
  function automatic dev_status_t status_next(
    input dev_status_t cur,
    input logic        change,
    input logic        data_rd,
    input logic        ctrl_wr,
    input logic        wr_ready,
    input logic        wr_overrun,
    input logic        wr_ie
  );
    dev_status_t nxt;
    nxt = cur;
    if (ctrl_wr) begin
      if (!wr_ready)   nxt.ready   = 1'b0;
      if (!wr_overrun) nxt.overrun = 1'b0;
      nxt.ie = wr_ie;
    end
    if (data_rd) nxt.ready = 1'b0;
    if (change) begin
      if (cur.ready && !data_rd) nxt.overrun = 1'b1;
      nxt.ready = 1'b1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/key_sw_ctrl_input_debouncer.sv
// rtl/key_sw_ctrl_input_debouncer.sv - 2-flop synchronizer plus vector debouncer
//
// Purpose: synchronize a raw input vector and accept a new value only after
//          it has been stable for DEBOUNCE_CYCLES cycles.
// Ports:   clk, reset    - clock, asynchronous active-high reset
//          i_raw         - raw asynchronous input vector
//          o_data        - debounced value
//          o_change      - high for the one cycle ending at the edge where
//                          o_data takes a different value
module input_debouncer #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 10000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_raw,
  output logic [WIDTH-1:0] o_data,
  output logic             o_change
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_cand;
  logic [WIDTH-1:0] r_out;
  logic [CW-1:0]    r_cnt;

  logic w_stable;
  logic w_done;
  logic w_change;

  // The candidate is loaded on the first differing sample (counter 0); each
  // further matching sample counts one stable cycle, and the output is
  // accepted on the sample after the counter has saturated.
  assign w_stable = (r_sync2 == r_cand);
  assign w_done   = (r_cnt == CNT_MAX);
  assign w_change = w_stable && w_done && (r_cand != r_out);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_cand  <= '0;
      r_out   <= '0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (!w_stable) begin
        r_cand <= r_sync2;
        r_cnt  <= '0;
      end else if (!w_done) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_change) r_out <= r_cand;
    end
  end

  assign o_data   = r_out;
  assign o_change = w_change;

endmodule

// File: rtl/key_sw_ctrl.sv
// rtl/key_sw_ctrl.sv - memory-mapped KEY/SW responder with status and irq
//
// Purpose: debounces KEY (active-low) and SW, exposes KDATA/KCTRL/SDATA/SCTRL
//          on the M-stage data bus, tracks Ready/Overrun/IE per device and
//          raises irq when an enabled device has unread data.
// Ports:   clk, reset       - clock, asynchronous active-high reset
//          KEY[3:0], SW[9:0]- raw board inputs
//          addr, wdata      - bus address and write data
//          we, re           - one-cycle store / load strobes
//          rdata, sel       - combinational read data and address hit
//          irq              - (KReady & KIE) | (SReady & SIE)
module key_sw_ctrl
  import key_sw_ctrl_pkg::*;
#(
  parameter int               DBITS           = 32,
  parameter logic [DBITS-1:0] ADDRKEY         = DBITS'(ADDRKEY_DEFAULT),
  parameter logic [DBITS-1:0] ADDRSW          = DBITS'(ADDRSW_DEFAULT),
  parameter int               DEBOUNCE_CYCLES = 10000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       KEY,
  input  logic [9:0]       SW,
  input  logic [DBITS-1:0] addr,
  input  logic [DBITS-1:0] wdata,
  input  logic             we,
  input  logic             re,
  output logic [DBITS-1:0] rdata,
  output logic             sel,
  output logic             irq
);

  localparam logic [DBITS-1:0] KCTRL_ADDR = ADDRKEY + DBITS'(CTRL_OFFSET);
  localparam logic [DBITS-1:0] SCTRL_ADDR = ADDRSW + DBITS'(CTRL_OFFSET);

  logic [3:0]  w_keys;
  logic [9:0]  w_sws;
  logic        w_kchange;
  logic        w_schange;
  logic        w_kdata_hit;
  logic        w_kctrl_hit;
  logic        w_sdata_hit;
  logic        w_sctrl_hit;
  logic        w_unused_wdata;
  dev_status_t r_kstat;
  dev_status_t r_sstat;

  // Keys are inverted ahead of the synchronizer so a pressed key reads as 1.
  input_debouncer #(
    .WIDTH           (4),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_key_db (
    .clk      (clk),
    .reset    (reset),
    .i_raw    (~KEY),
    .o_data   (w_keys),
    .o_change (w_kchange)
  );

  input_debouncer #(
    .WIDTH           (10),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_sw_db (
    .clk      (clk),
    .reset    (reset),
    .i_raw    (SW),
    .o_data   (w_sws),
    .o_change (w_schange)
  );

  assign w_kdata_hit = (addr == ADDRKEY);
  assign w_kctrl_hit = (addr == KCTRL_ADDR);
  assign w_sdata_hit = (addr == ADDRSW);
  assign w_sctrl_hit = (addr == SCTRL_ADDR);

  // Only the Ready, Overrun and IE bit positions of a CTRL write matter.
  assign w_unused_wdata = ^{wdata[DBITS-1:BIT_IE+1],
                            wdata[BIT_IE-1:BIT_OVERRUN+1],
                            wdata[BIT_OVERRUN-1:BIT_READY+1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_kstat <= '0;
      r_sstat <= '0;
    end else begin
      r_kstat <= status_next(r_kstat, w_kchange, re && w_kdata_hit,
                             we && w_kctrl_hit, wdata[BIT_READY],
                             wdata[BIT_OVERRUN], wdata[BIT_IE]);
      r_sstat <= status_next(r_sstat, w_schange, re && w_sdata_hit,
                             we && w_sctrl_hit, wdata[BIT_READY],
                             wdata[BIT_OVERRUN], wdata[BIT_IE]);
    end
  end

  always_comb begin
    rdata = '0;
    sel   = 1'b0;
    if (w_kdata_hit) begin
      sel         = 1'b1;
      rdata[3:0]  = w_keys;
    end else if (w_kctrl_hit) begin
      sel                = 1'b1;
      rdata[BIT_READY]   = r_kstat.ready;
      rdata[BIT_OVERRUN] = r_kstat.overrun;
      rdata[BIT_IE]      = r_kstat.ie;
    end else if (w_sdata_hit) begin
      sel         = 1'b1;
      rdata[9:0]  = w_sws;
    end else if (w_sctrl_hit) begin
      sel                = 1'b1;
      rdata[BIT_READY]   = r_sstat.ready;
      rdata[BIT_OVERRUN] = r_sstat.overrun;
      rdata[BIT_IE]      = r_sstat.ie;
    end
  end

  assign irq = (r_kstat.ready & r_kstat.ie) | (r_sstat.ready & r_sstat.ie);

endmodule

// File: tb/tb_key_sw_ctrl.sv
// tb/tb_key_sw_ctrl.sv - self-checking bench for key_sw_ctrl
module tb_key_sw_ctrl;

  localparam logic [31:0] A_KD = 32'hFFFFF080;
  localparam logic [31:0] A_KC = 32'hFFFFF084;
  localparam logic [31:0] A_SD = 32'hFFFFF090;
  localparam logic [31:0] A_SC = 32'hFFFFF094;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  KEY;
  logic [9:0]  SW;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        re;
  logic [31:0] rdata;
  logic        sel;
  logic        irq;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];

  key_sw_ctrl #(
    .DBITS           (32),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .KEY   (KEY),
    .SW    (SW),
    .addr  (addr),
    .wdata (wdata),
    .we    (we),
    .re    (re),
    .rdata (rdata),
    .sel   (sel),
    .irq   (irq)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected value is queued as the access is driven, then popped and
  // compared once the combinational read data has settled.
  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
    addr = a;
    #1;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk(e.tag, rdata, e.exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    tick(1);
    we    = 1'b0;
    wdata = '0;
  endtask

  initial begin
    reset = 1'b1;
    KEY   = 4'b1111;
    SW    = '0;
    addr  = '0;
    wdata = '0;
    we    = 1'b0;
    re    = 1'b0;
    tick(3);

    // Reset state
    rd("rst_kdata", A_KD, 32'h0);
    chk("rst_sel_kd", {31'b0, sel}, 32'd1);
    rd("rst_kctrl", A_KC, 32'h0);
    rd("rst_sdata", A_SD, 32'h0);
    rd("rst_sctrl", A_SC, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    reset = 1'b0;
    tick(20);
    rd("idle_kctrl", A_KC, 32'h0);
    rd("idle_sctrl", A_SC, 32'h0);

    // Unmapped addresses
    rd("unmap_088", 32'hFFFFF088, 32'h0);
    chk("unmap_sel", {31'b0, sel}, 32'd0);
    rd("unmap_098", 32'hFFFFF098, 32'h0);

    // Press KEY[1]: accepted at edge 7, not before
    KEY = 4'b1101;
    tick(6);
    rd("press_e6_kctrl", A_KC, 32'h0);
    rd("press_e6_kdata", A_KD, 32'h0);
    tick(1);
    rd("press_e7_kdata", A_KD, 32'h2);
    rd("press_e7_kctrl", A_KC, 32'h1);
    re = 1'b1;
    rd("press_read_kdata", A_KD, 32'h2);
    tick(1);
    re = 1'b0;
    rd("press_after_read_kctrl", A_KC, 32'h0);

    // Glitch on SW[3] shorter than the debounce window
    SW = 10'h008;
    tick(3);
    SW = 10'h000;
    tick(12);
    rd("glitch_sdata", A_SD, 32'h0);
    rd("glitch_sctrl", A_SC, 32'h0);

    // Two KEY changes without a read -> Ready + Overrun
    KEY = 4'b1111;
    tick(10);
    rd("chg1_kctrl", A_KC, 32'h1);
    rd("chg1_kdata", A_KD, 32'h0);
    KEY = 4'b1110;
    tick(10);
    rd("chg2_kctrl", A_KC, 32'h5);
    rd("chg2_kdata", A_KD, 32'h1);
    wr(A_KC, 32'h0);
    rd("kctrl_clr", A_KC, 32'h0);

    // Interrupt from switches
    wr(A_SC, 32'h100);
    rd("sctrl_ie", A_SC, 32'h100);
    chk("irq_before_sw", {31'b0, irq}, 32'd0);
    SW = 10'h001;
    tick(6);
    chk("irq_e6", {31'b0, irq}, 32'd0);
    tick(1);
    chk("irq_e7", {31'b0, irq}, 32'd1);
    rd("sctrl_ready_ie", A_SC, 32'h101);
    re = 1'b1;
    rd("sdata_read", A_SD, 32'h1);
    tick(1);
    re = 1'b0;
    chk("irq_after_read", {31'b0, irq}, 32'd0);
    rd("sctrl_after_read", A_SC, 32'h100);

    // Change lands on the same edge as a KDATA read with Ready=1
    KEY = 4'b1111;
    tick(10);
    rd("coll_pre_kctrl", A_KC, 32'h1);
    KEY = 4'b1011;
    tick(6);
    re = 1'b1;
    rd("coll_read_kdata", A_KD, 32'h0);
    tick(1);
    re = 1'b0;
    rd("coll_kctrl", A_KC, 32'h1);
    rd("coll_kdata", A_KD, 32'h4);

    // Writing Ready=1 is ignored, IE is stored
    wr(A_KC, 32'h101);
    rd("kctrl_ie", A_KC, 32'h101);
    chk("irq_key", {31'b0, irq}, 32'd1);

    // Reset mid-debounce
    SW = 10'h021;
    tick(3);
    reset = 1'b1;
    #1;
    chk("midrst_irq", {31'b0, irq}, 32'd0);
    rd("midrst_kctrl", A_KC, 32'h0);
    rd("midrst_sctrl", A_SC, 32'h0);
    rd("midrst_kdata", A_KD, 32'h0);
    rd("midrst_sdata", A_SD, 32'h0);
    tick(2);
    reset = 1'b0;
    tick(10);
    rd("post_rst_kdata", A_KD, 32'h4);
    rd("post_rst_sdata", A_SD, 32'h21);
    rd("post_rst_kctrl", A_KC, 32'h1);
    rd("post_rst_sctrl", A_SC, 32'h1);
    chk("post_rst_irq", {31'b0, irq}, 32'd0);

    // Writes to a data register are ignored
    wr(A_KD, 32'hFFFF_FFFF);
    rd("kdata_wr_ignored", A_KD, 32'h4);
    rd("kctrl_after_kd_wr", A_KC, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/key_sw_ctrl.md
# key_sw_ctrl

Memory-mapped responder for the board's push-buttons (KEY) and slide switches (SW), sitting on the CPU's M-stage data bus beside the HEX/LEDR output registers. It synchronizes and debounces the raw inputs, holds a debounced data register per device, and tracks per-device Ready/Overrun/IE status. Loads from the data registers have read side effects; the block raises an interrupt line when an enabled device has unread data.

## Interface
- DBITS, 32, bus data/address width
- ADDRKEY, 32'hFFFFF080, KDATA address; KCTRL is at ADDRKEY+4
- ADDRSW, 32'hFFFFF090, SDATA address; SCTRL is at ADDRSW+4
- DEBOUNCE_CYCLES, 10000, consecutive stable cycles required to accept a change; minimum 2
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- KEY  in  4  raw push-buttons, active-low
- SW  in  10  raw switches, active-high
- addr  in  DBITS  bus address (memaddr)
- wdata  in  DBITS  bus write data
- we  in  1  write strobe, one cycle per store
- re  in  1  read strobe, one cycle per load; drives read side effects
- rdata  out  DBITS  read data, combinational from addr
- sel  out  1  addr matches one of the four registers
- irq  out  1  (KReady & KIE) | (SReady & SIE)

## Operation
- Input path per device: 2-flop synchronizer, then debouncer. KEY is inverted before the synchronizer, so the KDATA bit is 1 while the key is pressed.
- Debouncer holds a candidate value and a stability counter. When the synchronized value differs from the candidate, it loads the candidate and clears the counter. The debounced output takes the candidate once the candidate has been stable for DEBOUNCE_CYCLES cycles. A pulse shorter than DEBOUNCE_CYCLES cycles never reaches the output.
- A "change" is any cycle in which the debounced output updates to a different value.
- KDATA read layout: {28'b0, keys}.
- SDATA read layout: {22'b0, switches}.
- KCTRL/SCTRL read layout: bit0 Ready, bit2 Overrun, bit8 IE; all other bits 0.
- On a change: if Ready=0, set Ready. If Ready=1 and the same cycle is not a read of that data register, set Overrun.
- re with addr==KDATA (or SDATA): clear that device's Ready at the clock edge.
- Write to CTRL:
  - bit0 written 0 clears Ready; written 1 is ignored.
  - bit2 written 0 clears Overrun; written 1 is ignored.
  - bit8 stores IE.
- Writes to KDATA/SDATA are ignored.
- rdata=0 and sel=0 for any other address.
- Simultaneous events, per device:
  - Change plus data read in the same cycle: Ready ends at 1, Overrun unchanged.
  - Change plus CTRL write of Ready=0: Ready ends at 1.
  - Change plus CTRL write of Overrun=0 while Ready=1: Overrun ends at 1 (set wins).
- Reset, including mid-debounce, forces:
  - Synchronizers, candidates and debounced outputs to 0, counters to 0.
  - Ready, Overrun and IE to 0; irq to 0.
- Switches already at 1 after reset produce one change once debounced, which sets SReady.

## Timing
- Raw input changes before edge 1 and stays stable: the debounced value, and Ready/Overrun, update at edge DEBOUNCE_CYCLES+3. With DEBOUNCE_CYCLES=4 this is edge 7.
- rdata and sel are combinational from addr and current register state, in the same cycle as the access.
- Ready clear and CTRL write updates take effect at the edge that ends the re/we cycle. They are visible to an access in the next cycle.
- irq is combinational from flops and asserts in the cycle after the edge that sets Ready with IE=1.
- Status bits never change value except at a clock edge or at reset.

## Structure
- Shared package: ADDRKEY/ADDRSW defaults, the CTRL offset (4), and the bit positions READY=0, OVERRUN=2, IE=8.
- One sub-module: input_debouncer, parameterized by WIDTH and DEBOUNCE_CYCLES. It contains the synchronizer, candidate register and counter, and outputs the debounced value and a one-cycle change pulse.
- It is instantiated twice: WIDTH=4 for KEY, WIDTH=10 for SW.
- Status registers and address decode live in key_sw_ctrl.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Reset asserted with KEY=4'b1111 and SW=0: rdata=0 at all four addresses, irq=0. Release reset, idle 20 cycles: KCTRL and SCTRL still read 0.
- Press KEY[1] (KEY=4'b1101) before edge 1:
  - Expected: KDATA=2 and KCTRL=1 after edge 7.
  - Read KDATA with re: KCTRL=0 next cycle.
- Glitch: SW[3]=1 for 3 cycles, then 0 -> SDATA stays 0 and SReady stays 0.
- Two KEY changes without a read -> KCTRL=0x5. Write KCTRL=0 -> KCTRL=0x0.
- Write SCTRL=0x100, then flip SW[0] -> irq=1 once SReady sets. Read SDATA -> irq=0 next cycle.
- Collisions:
  - Debounced change lands on the same edge as an re of KDATA with Ready=1: KCTRL ends 0x1.
  - Assert reset mid-debounce: all status bits and irq return to 0 immediately.
